// File: rtl/spi_prot_rx_if.sv
// Signal bundle between the snooped SPI lines / trigger config and spi_prot_rx.
// master drives the pins and config, slave is the receiver.
interface spi_prot_rx_if;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        edg;
  logic        len8;
  logic [15:0] mask;
  logic [15:0] match;
  logic        SPItrig;
  logic [15:0] rx_data;
  logic [4:0]  bit_cnt;

  modport master (
    output SS_n, SCLK, MOSI, edg, len8, mask, match,
    input  SPItrig, rx_data, bit_cnt
  );

  modport slave (
    input  SS_n, SCLK, MOSI, edg, len8, mask, match,
    output SPItrig, rx_data, bit_cnt
  );
endinterface

// File: rtl/spi_prot_rx.sv
// Passive SPI snooper: shifts in a frame and pulses SPItrig when the word seen
// at SS_n rise matches the masked compare value.
//
// state | meaning
// IDLE  | SS_n high, SCLK ignored, rx_data/bit_cnt hold last frame
// RX    | SS_n low, shifting on the selected SCLK edge
module spi_prot_rx (
  input  logic             clk,
  input  logic             rst_n,
  spi_prot_rx_if.slave     bus
);

  typedef enum logic {IDLE, RX} state_t;

  state_t      r_state;
  logic        r_ss_ff1, r_ss_ff2, r_ss_ff3;
  logic        r_sclk_ff1, r_sclk_ff2, r_sclk_ff3;
  logic        r_mosi_ff1, r_mosi_ff2, r_mosi_ff3;
  logic [15:0] r_rx_data;
  logic [4:0]  r_bit_cnt;
  logic        r_trig;

  logic        w_ss_fall, w_ss_rise;
  logic        w_sclk_fall, w_sclk_rise;
  logic        w_shift;
  logic [15:0] w_rx_next;
  logic [4:0]  w_cnt_next;
  logic        w_hit8, w_hit16, w_hit;

  assign w_ss_fall   = ~r_ss_ff2 & r_ss_ff3;
  assign w_ss_rise   =  r_ss_ff2 & ~r_ss_ff3;
  assign w_sclk_fall = ~r_sclk_ff2 & r_sclk_ff3;
  assign w_sclk_rise =  r_sclk_ff2 & ~r_sclk_ff3;
  assign w_shift     = bus.edg ? w_sclk_rise : w_sclk_fall;

  // Compare sees the post-shift word when an SCLK edge coincides with SS_n rise.
  assign w_rx_next  = w_shift ? {r_rx_data[14:0], r_mosi_ff3} : r_rx_data;
  assign w_cnt_next = (w_shift && (r_bit_cnt != 5'd31)) ? r_bit_cnt + 5'd1 : r_bit_cnt;

  assign w_hit8  = (((w_rx_next[7:0] ^ bus.match[7:0]) & ~bus.mask[7:0]) == 8'h00)
                   && (w_cnt_next >= 5'd8);
  assign w_hit16 = (((w_rx_next ^ bus.match) & ~bus.mask) == 16'h0000)
                   && (w_cnt_next >= 5'd16);
  assign w_hit   = bus.len8 ? w_hit8 : w_hit16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ss_ff1   <= 1'b1;
      r_ss_ff2   <= 1'b1;
      r_ss_ff3   <= 1'b1;
      r_sclk_ff1 <= 1'b1;
      r_sclk_ff2 <= 1'b1;
      r_sclk_ff3 <= 1'b1;
      r_mosi_ff1 <= 1'b0;
      r_mosi_ff2 <= 1'b0;
      r_mosi_ff3 <= 1'b0;
      r_rx_data  <= 16'h0000;
      r_bit_cnt  <= 5'd0;
      r_trig     <= 1'b0;
    end else begin
      r_ss_ff1   <= bus.SS_n;
      r_ss_ff2   <= r_ss_ff1;
      r_ss_ff3   <= r_ss_ff2;
      r_sclk_ff1 <= bus.SCLK;
      r_sclk_ff2 <= r_sclk_ff1;
      r_sclk_ff3 <= r_sclk_ff2;
      r_mosi_ff1 <= bus.MOSI;
      r_mosi_ff2 <= r_mosi_ff1;
      r_mosi_ff3 <= r_mosi_ff2;
      r_trig     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state   <= RX;
            r_rx_data <= 16'h0000;
            r_bit_cnt <= 5'd0;
          end
        end
        RX: begin
          r_rx_data <= w_rx_next;
          r_bit_cnt <= w_cnt_next;
          if (w_ss_rise) begin
            r_state <= IDLE;
            r_trig  <= w_hit;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.SPItrig = r_trig;
  assign bus.rx_data = r_rx_data;
  assign bus.bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_spi_prot_rx.sv
// Self-checking bench for spi_prot_rx: an SPI master task drives frames at
// clk/32 and a scoreboard holds the expected trigger/data per frame.
module tb_spi_prot_rx;

  logic clk;
  logic rst_n;

  spi_prot_rx_if bus ();

  spi_prot_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trig;
    logic [15:0] rx;
    logic [4:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam int HALF = 16;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Idle SCLK level is chosen so the first toggle is the sampling edge.
  task automatic set_mode(input logic e, input logic l8, input logic [15:0] mt,
                          input logic [15:0] mk);
    bus.edg   = e;
    bus.len8  = l8;
    bus.match = mt;
    bus.mask  = mk;
    bus.SCLK  = e ? 1'b0 : 1'b1;
    wait_clks(8);
  endtask

  task automatic shift_bits(input logic [31:0] val, input int hi, input int lo,
                            inout logic [15:0] m_rx, inout int m_cnt);
    for (int i = hi; i >= lo; i--) begin
      bus.MOSI = val[i];
      wait_clks(HALF);
      bus.SCLK = ~bus.SCLK;
      m_rx = {m_rx[14:0], val[i]};
      if (m_cnt < 31) m_cnt++;
      wait_clks(HALF);
      bus.SCLK = ~bus.SCLK;
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits, input logic exp_trig);
    logic [15:0] m_rx;
    int          m_cnt;
    exp_t        e;
    m_rx  = 16'h0000;
    m_cnt = 0;
    bus.SS_n = 1'b0;
    wait_clks(HALF);
    shift_bits(val, nbits - 1, 0, m_rx, m_cnt);
    wait_clks(HALF);
    e.trig = exp_trig;
    e.rx   = m_rx;
    e.cnt  = 5'(m_cnt);
    sb.push_back(e);
    bus.SS_n = 1'b1;
  endtask

  // Called right after SS_n rises; the next posedge is edge 1.
  task automatic check_frame(input string name);
    exp_t e;
    int   hits;
    int   first;
    hits  = 0;
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.SPItrig === 1'b1) begin
        hits++;
        if (first == 0) first = i;
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (e.trig ? (hits != 1 || first != 3) : (hits != 0)) begin
        errors++;
        $display("FAIL %s trig: pulses=%0d first_edge=%0d, required pulses=%0d at edge 3",
                 name, hits, first, e.trig ? 1 : 0);
      end
      checks++;
      if (bus.rx_data !== e.rx) begin
        errors++;
        $display("FAIL %s rx_data: got %h, required %h", name, bus.rx_data, e.rx);
      end
      checks++;
      if (bus.bit_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s bit_cnt: got %0d, required %0d", name, bus.bit_cnt, e.cnt);
      end
    end
    wait_clks(8);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.SPItrig !== 1'b0) begin
      errors++;
      $display("FAIL reset SPItrig: got %b, required 0", bus.SPItrig);
    end
    checks++;
    if (bus.rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset rx_data: got %h, required 0000", bus.rx_data);
    end
    checks++;
    if (bus.bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset bit_cnt: got %0d, required 0", bus.bit_cnt);
    end
  endtask

  task automatic test_len8();
    set_mode(1'b0, 1'b1, 16'h0066, 16'h0000);
    send_frame(32'h66, 8, 1'b1); check_frame("len8_66");
    send_frame(32'h67, 8, 1'b0); check_frame("len8_67");
    set_mode(1'b0, 1'b1, 16'h0066, 16'h0001);
    send_frame(32'h67, 8, 1'b1); check_frame("len8_67_mask");
  endtask

  task automatic test_len16();
    set_mode(1'b1, 1'b0, 16'hA5C3, 16'h0000);
    send_frame(32'hA5C3, 16, 1'b1); check_frame("len16_a5c3");
    send_frame(32'hA5C2, 16, 1'b0); check_frame("len16_a5c2");
  endtask

  task automatic test_short();
    exp_t e;
    set_mode(1'b1, 1'b1, 16'h0066, 16'h0000);
    send_frame(32'h0C, 5, 1'b0); check_frame("short5");
    bus.SS_n = 1'b0;
    wait_clks(10);
    e.trig = 1'b0;
    e.rx   = 16'h0000;
    e.cnt  = 5'd0;
    sb.push_back(e);
    bus.SS_n = 1'b1;
    check_frame("ss_glitch");
  endtask

  task automatic test_reset_midframe();
    logic [15:0] m_rx;
    int          m_cnt;
    int          hits;
    m_rx  = 16'h0000;
    m_cnt = 0;
    hits  = 0;
    set_mode(1'b0, 1'b1, 16'h0066, 16'h0000);
    bus.SS_n = 1'b0;
    wait_clks(HALF);
    shift_bits(32'h66, 7, 4, m_rx, m_cnt);
    wait_clks(4);
    checks++;
    if (bus.rx_data !== 16'h0006 || bus.bit_cnt !== 5'd4) begin
      errors++;
      $display("FAIL midframe before reset: rx=%h cnt=%0d, required 0006/4",
               bus.rx_data, bus.bit_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.SPItrig !== 1'b0 || bus.rx_data !== 16'h0000 || bus.bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL midframe reset: trig=%b rx=%h cnt=%0d, required 0/0000/0",
               bus.SPItrig, bus.rx_data, bus.bit_cnt);
    end
    wait_clks(3);
    rst_n = 1'b1;
    shift_bits(32'h66, 3, 0, m_rx, m_cnt);
    wait_clks(HALF);
    bus.SS_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.SPItrig === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL midframe trig: pulses=%0d, required 0", hits);
    end
    wait_clks(8);
    send_frame(32'h66, 8, 1'b1); check_frame("after_reset_66");
  endtask

  task automatic test_long();
    set_mode(1'b1, 1'b0, 16'hA5C3, 16'h0000);
    send_frame(32'h5AA5C3, 24, 1'b1); check_frame("long24");
  endtask

  task automatic test_back_to_back();
    set_mode(1'b0, 1'b1, 16'h0F3C, 16'hFF00);
    send_frame(32'h3C, 8, 1'b1); check_frame("b2b_1");
    send_frame(32'hBC, 8, 1'b0); check_frame("b2b_2");
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.SS_n  = 1'b1;
    bus.SCLK  = 1'b1;
    bus.MOSI  = 1'b0;
    bus.edg   = 1'b0;
    bus.len8  = 1'b1;
    bus.mask  = 16'h0000;
    bus.match = 16'h0000;
    wait_clks(4);
    test_reset();
    rst_n = 1'b1;
    wait_clks(4);
    test_len8();
    test_len16();
    test_short();
    test_reset_midframe();
    test_long();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: %0d entries, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
